rf_cmd_ctrl: RTL and testbench

RF_CMD_CTRL -- requirements
Module: rf_cmd_ctrl

---
 rtl/rf_cmd_ctrl_if.sv | 29 ++
 rtl/rf_cmd_ctrl.sv | 105 ++++++++++
 tb/tb_rf_cmd_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rf_cmd_ctrl_if.sv
// Bus between the UART/register-file side and the command controller.
// The controller takes the slave modport; whatever drives it uses master.
interface rf_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADD_W  = 4
);
  logic [DATA_W-1:0] RX_P_Data;
  logic              RX_D_VLD;
  logic [DATA_W-1:0] RdData;
  logic              RdData_Valid;
  logic              TX_Busy;
  logic [ADD_W-1:0]  Address;
  logic [DATA_W-1:0] WrData;
  logic              WrEn;
  logic              RdEn;
  logic [DATA_W-1:0] TX_P_Data;
  logic              TX_D_VLD;
  logic              Cmd_Err;

  modport slave (
    input  RX_P_Data, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
    output Address, WrData, WrEn, RdEn, TX_P_Data, TX_D_VLD, Cmd_Err
  );

  modport master (
    output RX_P_Data, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
    input  Address, WrData, WrEn, RdEn, TX_P_Data, TX_D_VLD, Cmd_Err
  );
endinterface

// File: rtl/rf_cmd_ctrl.sv
// UART command decoder: 0xAA addr data writes the register file, 0xBB addr
// reads it and sends the value back. All outputs come straight from flops.
module rf_cmd_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADD_W  = 4
) (
  input  logic         Clk,
  input  logic         RST_n,
  rf_cmd_ctrl_if.slave bus
);
  localparam logic [DATA_W-1:0] CMD_WR = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] CMD_RD = DATA_W'(8'hBB);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_WAIT, TX_SEND
  } state_t;

  state_t            state_q;
  logic [ADD_W-1:0]  addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] tx_buf_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [1:0]        tmo_q;
  logic              wr_en_q, rd_en_q, tx_vld_q, err_q;

  // Strobes are set on the edge that enters WR_EXEC/RD_EXEC/TX_SEND, so each
  // is high for exactly the one cycle the FSM spends in that state.
  always_ff @(posedge Clk) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      tx_buf_q  <= '0;
      tx_data_q <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      tx_vld_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: if (bus.RX_D_VLD) begin
          if (bus.RX_P_Data == CMD_WR)      state_q <= WR_ADDR;
          else if (bus.RX_P_Data == CMD_RD) state_q <= RD_ADDR;
          else                              err_q   <= 1'b1;
        end
        WR_ADDR, RD_ADDR: if (bus.RX_D_VLD) begin
          // Out-of-range address aborts without touching the address register.
          if (|bus.RX_P_Data[DATA_W-1:ADD_W]) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            addr_q <= bus.RX_P_Data[ADD_W-1:0];
            if (state_q == WR_ADDR) begin
              state_q <= WR_DATA;
            end else begin
              state_q <= RD_EXEC;
              rd_en_q <= 1'b1;
            end
          end
        end
        WR_DATA: if (bus.RX_D_VLD) begin
          data_q  <= bus.RX_P_Data;
          wr_en_q <= 1'b1;
          state_q <= WR_EXEC;
        end
        WR_EXEC: state_q <= IDLE;
        RD_EXEC: begin
          tmo_q   <= '0;
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (bus.RdData_Valid) begin
            tx_buf_q <= bus.RdData;
            state_q  <= TX_WAIT;
          end else if (tmo_q == 2'd3) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 2'd1;
          end
        end
        TX_WAIT: if (!bus.TX_Busy) begin
          tx_data_q <= tx_buf_q;
          tx_vld_q  <= 1'b1;
          state_q   <= TX_SEND;
        end
        TX_SEND: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Address   = addr_q;
  assign bus.WrData    = data_q;
  assign bus.WrEn      = wr_en_q;
  assign bus.RdEn      = rd_en_q;
  assign bus.TX_P_Data = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.Cmd_Err   = err_q;
endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Directed bench for rf_cmd_ctrl: write, read, busy transmitter, protocol
// errors, read timeout and mid-command reset.
module tb_rf_cmd_ctrl;
  logic Clk = 1'b0;
  logic RST_n = 1'b0;
  always #5 Clk = ~Clk;

  rf_cmd_ctrl_if #(.DATA_W(8), .ADD_W(4)) bus ();
  rf_cmd_ctrl #(.DATA_W(8), .ADD_W(4)) dut (.Clk(Clk), .RST_n(RST_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0, both_cnt = 0, dbl_err = 0;
  logic err_prev = 1'b0;
  int w0, r0, t0, e0;

  // Pulse monitor sampled mid-cycle.
  always @(negedge Clk) begin
    if (bus.WrEn)               wr_cnt++;
    if (bus.RdEn)               rd_cnt++;
    if (bus.TX_D_VLD)           tx_cnt++;
    if (bus.Cmd_Err)            err_cnt++;
    if (bus.WrEn && bus.RdEn)   both_cnt++;
    if (bus.Cmd_Err && err_prev) dbl_err++;
    err_prev = bus.Cmd_Err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.RX_P_Data = b;
    bus.RX_D_VLD  = 1'b1;
    tick();
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic snap();
    w0 = wr_cnt; r0 = rd_cnt; t0 = tx_cnt; e0 = err_cnt;
  endtask

  initial begin
    bus.RX_P_Data = '0; bus.RX_D_VLD = 1'b0; bus.RdData = '0;
    bus.RdData_Valid = 1'b0; bus.TX_Busy = 1'b0;
    tick(); tick();
    RST_n = 1'b1;
    chk("rst_outputs", 32'({bus.Address, bus.WrData, bus.TX_P_Data,
                            bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.Cmd_Err}), 0);

    // Write AA 05 3C
    snap();
    send(8'hAA);
    send(8'h05);
    chk("wr_addr", 32'(bus.Address), 5);
    chk("wr_en_early", 32'(bus.WrEn), 0);
    send(8'h3C);
    chk("wr_en", 32'(bus.WrEn), 1);
    chk("wr_data", 32'(bus.WrData), 32'h3C);
    tick();
    chk("wr_en_off", 32'(bus.WrEn), 0);
    chk("wr_cnt", 32'(wr_cnt - w0), 1);
    chk("wr_no_rd_err", 32'((rd_cnt - r0) + (err_cnt - e0)), 0);

    // Read BB 02, RF returns 0x81 the cycle after RdEn
    snap();
    send(8'hBB);
    send(8'h02);
    chk("rd_en", 32'(bus.RdEn), 1);
    chk("rd_addr", 32'(bus.Address), 2);
    tick();
    chk("rd_en_off", 32'(bus.RdEn), 0);
    bus.RdData = 8'h81; bus.RdData_Valid = 1'b1;
    tick();
    bus.RdData_Valid = 1'b0; bus.RdData = 8'h00;
    chk("tx_not_yet", 32'(bus.TX_D_VLD), 0);
    tick();
    chk("tx_vld", 32'(bus.TX_D_VLD), 1);
    chk("tx_data", 32'(bus.TX_P_Data), 32'h81);
    tick();
    chk("tx_vld_off", 32'(bus.TX_D_VLD), 0);
    chk("rd_counts", 32'({8'(rd_cnt - r0), 8'(tx_cnt - t0), 8'(err_cnt - e0), 8'(wr_cnt - w0)}),
        32'h01010000);

    // Read with busy transmitter; bytes received meanwhile are dropped
    snap();
    bus.TX_Busy = 1'b1;
    send(8'hBB);
    send(8'h07);
    tick();
    bus.RdData = 8'h5A; bus.RdData_Valid = 1'b1;
    tick();
    bus.RdData_Valid = 1'b0; bus.RdData = 8'h00;
    send(8'hAA);
    send(8'h55);
    repeat (4) tick();
    send(8'h03);
    chk("busy_no_tx", 32'(tx_cnt - t0), 0);
    chk("busy_no_err", 32'(err_cnt - e0), 0);
    bus.TX_Busy = 1'b0;
    tick();
    chk("busy_tx_vld", 32'(bus.TX_D_VLD), 1);
    chk("busy_tx_data", 32'(bus.TX_P_Data), 32'h5A);
    tick();
    tick();
    chk("busy_tx_once", 32'(tx_cnt - t0), 1);
    chk("busy_addr", 32'(bus.Address), 7);
    // FSM must be back in IDLE accepting a fresh write
    snap();
    send(8'hAA); send(8'h03); send(8'h11);
    chk("post_busy_wr", 32'({bus.WrEn, bus.Address, bus.WrData}), 32'h1311);
    tick();
    chk("post_busy_cnt", 32'(wr_cnt - w0), 1);

    // Errors
    snap();
    send(8'h55);
    chk("bad_cmd_err", 32'(bus.Cmd_Err), 1);
    tick();
    chk("bad_cmd_err_off", 32'(bus.Cmd_Err), 0);
    send(8'hAA);
    send(8'h12);
    chk("bad_addr_err", 32'(bus.Cmd_Err), 1);
    chk("bad_addr_keep", 32'(bus.Address), 3);
    tick();
    send(8'hBB);
    send(8'h01);
    chk("tmo_rd_en", 32'({bus.RdEn, bus.Address}), 32'h11);
    repeat (4) tick();
    chk("tmo_not_yet", 32'(bus.Cmd_Err), 0);
    tick();
    chk("tmo_err", 32'(bus.Cmd_Err), 1);
    tick();
    chk("tmo_err_off", 32'(bus.Cmd_Err), 0);
    chk("err_counts", 32'({8'(err_cnt - e0), 8'(wr_cnt - w0), 8'(tx_cnt - t0)}), 32'h030000);

    // Reset mid-write
    snap();
    send(8'hAA);
    send(8'h05);
    chk("pre_rst_addr", 32'(bus.Address), 5);
    RST_n = 1'b0;
    tick();
    RST_n = 1'b1;
    chk("mid_rst_outputs", 32'({bus.Address, bus.WrData, bus.TX_P_Data,
                                bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.Cmd_Err}), 0);
    send(8'h3C);
    chk("post_rst_err", 32'(bus.Cmd_Err), 1);
    tick(); tick();
    chk("post_rst_counts", 32'({8'(err_cnt - e0), 8'(wr_cnt - w0), 8'(rd_cnt - r0)}), 32'h010000);

    chk("wr_rd_overlap", 32'(both_cnt), 0);
    chk("err_double", 32'(dbl_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
